// File: rtl/core_img_sequencer.sv
// rtl/core_img_sequencer.sv - steps the neuron array through T timesteps and counts spikes per neuron
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start_core_img        1-cycle start pulse (accepted only in IDLE with i_coring high)
//   i_coring                core-phase level; dropping it aborts a run without a done pulse
//   o_step_req, o_step_ts   timestep request and index towards the neuron array
//   i_step_ack, i_spikes_in 1-cycle ack and the spikes it qualifies
//   o_done_core_img         1-cycle completion pulse (normal end or ack timeout)
//   o_busy                  presentation in progress
//   o_err_timeout           sticky flag: last run ended on an ack timeout
//   o_spike_count           saturating per-neuron counts, neuron n at [n*CW +: CW]
module core_img_sequencer #(
    parameter int N      = 8,
    parameter int T      = 350,
    parameter int TW     = 9,
    parameter int CW     = 9,
    parameter int ACK_TO = 1023
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start_core_img,
    input  logic            i_coring,
    output logic            o_step_req,
    output logic [TW-1:0]   o_step_ts,
    input  logic            i_step_ack,
    input  logic [N-1:0]    i_spikes_in,
    output logic            o_done_core_img,
    output logic            o_busy,
    output logic            o_err_timeout,
    output logic [N*CW-1:0] o_spike_count
);
    localparam int              WW        = $clog2(ACK_TO + 1);
    localparam logic [TW-1:0]   TS_LAST   = TW'(T - 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(ACK_TO - 1);
    localparam logic [CW-1:0]   CNT_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

    state_t          r_state,    w_state;
    logic            r_step_req, w_step_req;
    logic [TW-1:0]   r_step_ts,  w_step_ts;
    logic            r_done,     w_done;
    logic            r_busy,     w_busy;
    logic            r_err,      w_err;
    logic [N*CW-1:0] r_cnt,      w_cnt;
    logic [WW-1:0]   r_wait,     w_wait;
    logic [N*CW-1:0] w_cnt_acc;

    // Counts after accepting the current spikes; each counter sticks at its maximum.
    always_comb begin
        w_cnt_acc = r_cnt;
        for (int n = 0; n < N; n++) begin
            if (i_spikes_in[n] && (r_cnt[n*CW +: CW] != CNT_MAX)) begin
                w_cnt_acc[n*CW +: CW] = r_cnt[n*CW +: CW] + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_step_req <= 1'b0;
            r_step_ts  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_wait     <= '0;
        end else begin
            r_state    <= w_state;
            r_step_req <= w_step_req;
            r_step_ts  <= w_step_ts;
            r_done     <= w_done;
            r_busy     <= w_busy;
            r_err      <= w_err;
            r_cnt      <= w_cnt;
            r_wait     <= w_wait;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_step_req = r_step_req;
        w_step_ts  = r_step_ts;
        w_done     = 1'b0;
        w_busy     = r_busy;
        w_err      = r_err;
        w_cnt      = r_cnt;
        w_wait     = r_wait;
        case (r_state)
            S_IDLE: begin
                if (i_start_core_img && i_coring) begin
                    w_state    = S_REQ;
                    w_step_req = 1'b1;
                    w_step_ts  = '0;
                    w_cnt      = '0;
                    w_err      = 1'b0;
                    w_busy     = 1'b1;
                    w_wait     = '0;
                end
            end
            S_REQ: begin
                // Abort outranks everything; an ack at the timeout edge still counts.
                if (!i_coring) begin
                    w_state    = S_IDLE;
                    w_step_req = 1'b0;
                    w_busy     = 1'b0;
                end else if (i_step_ack) begin
                    w_step_req = 1'b0;
                    w_cnt      = w_cnt_acc;
                    if (r_step_ts == TS_LAST) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                    end else begin
                        w_state   = S_GAP;
                        w_step_ts = r_step_ts + TW'(1);
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_state    = S_DONE;
                    w_step_req = 1'b0;
                    w_done     = 1'b1;
                    w_busy     = 1'b0;
                    w_err      = 1'b1;
                end else begin
                    w_wait = r_wait + WW'(1);
                end
            end
            S_GAP: begin
                if (!i_coring) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end else begin
                    w_state    = S_REQ;
                    w_step_req = 1'b1;
                    w_wait     = '0;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_step_req      = r_step_req;
    assign o_step_ts       = r_step_ts;
    assign o_done_core_img = r_done;
    assign o_busy          = r_busy;
    assign o_err_timeout   = r_err;
    assign o_spike_count   = r_cnt;
endmodule

// File: tb/tb_core_img_sequencer.sv
// tb/tb_core_img_sequencer.sv - self-checking bench for core_img_sequencer
module tb_core_img_sequencer;
    localparam int N = 8, T = 4, TW = 2, CW = 4, ACK_TO = 8;
    localparam int T2 = 20, TW2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, coring, ack;
    logic [7:0]    spk;
    logic          req, done, busy, err;
    logic [TW-1:0] ts;
    logic [31:0]   cnt;

    logic           d2_start, d2_coring, d2_ack;
    logic [7:0]     d2_spk;
    logic           d2_req, d2_done, d2_busy, d2_err;
    logic [TW2-1:0] d2_ts;
    logic [31:0]    d2_cnt;

    core_img_sequencer #(.N(N), .T(T), .TW(TW), .CW(CW), .ACK_TO(ACK_TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_core_img(start), .i_coring(coring),
        .o_step_req(req), .o_step_ts(ts), .i_step_ack(ack), .i_spikes_in(spk),
        .o_done_core_img(done), .o_busy(busy), .o_err_timeout(err), .o_spike_count(cnt)
    );

    core_img_sequencer #(.N(N), .T(T2), .TW(TW2), .CW(CW), .ACK_TO(ACK_TO)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_core_img(d2_start), .i_coring(d2_coring),
        .o_step_req(d2_req), .o_step_ts(d2_ts), .i_step_ack(d2_ack), .i_spikes_in(d2_spk),
        .o_done_core_img(d2_done), .o_busy(d2_busy), .o_err_timeout(d2_err), .o_spike_count(d2_cnt)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int d2_done_n = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        err;
    } done_exp_t;

    int        ts_q[$];
    done_exp_t done_q[$];

    typedef struct {
        logic [7:0]  spk;
        int          d;
        int          lat;
        logic [31:0] cnt;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    function automatic logic [31:0] model_cnt(input logic [7:0] s, input int steps);
        logic [31:0] r;
        r = '0;
        for (int n = 0; n < N; n++) begin
            if (s[n]) r[n*CW +: CW] = (steps > 15) ? 4'hF : 4'(steps);
        end
        return r;
    endfunction

    // Scoreboard: pop expectations as the DUT presents handshakes and done pulses.
    always @(negedge clk) begin : mon
        int        et;
        done_exp_t ed;
        if (rst_n) begin
            if (req && ack) begin
                if (ts_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: got ack at ts %0d expected none", ts);
                end else begin
                    et = ts_q.pop_front();
                    chk("step_ts", 64'(ts), 64'(et));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done=1 expected done=0");
                end else begin
                    ed = done_q.pop_front();
                    chk("done_count", 64'(cnt), 64'(ed.cnt));
                    chk("done_err", 64'(err), 64'(ed.err));
                end
            end
            if (d2_done) d2_done_n++;
        end
    end

    task automatic start_run();
        start = 1'b1; coring = 1'b1;
        tick();
        start = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic ack_step(input logic [7:0] s, input int d, input int exp_ts);
        int w;
        w = 0;
        while (!req && w < 16) begin
            tick();
            w++;
        end
        if (!req) begin
            chk("req_rise", 64'(req), 64'(1));
            return;
        end
        repeat (d) tick();
        ts_q.push_back(exp_ts);
        ack = 1'b1; spk = s;
        tick();
        ack = 1'b0; spk = 8'h00;
    endtask

    task automatic full_run(input logic [7:0] s, input int exp_lat);
        start_run();
        for (int i = 0; i < T; i++) begin
            if (i == T - 1) done_q.push_back(done_exp_t'{model_cnt(s, T), 1'b0});
            ack_step(s, 0, i);
        end
        chk("run_latency", 64'(edge_cnt), 64'(exp_lat));
        chk("run_done", 64'(done), 64'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int held;
        int bad;
        int w;
        vecs[0] = '{spk: 8'h01, d: 0, lat: 7,  cnt: 32'h0000_0004};
        vecs[1] = '{spk: 8'hA5, d: 1, lat: 11, cnt: 32'h4040_0404};
        vecs[2] = '{spk: 8'h3C, d: 2, lat: 15, cnt: 32'h0044_4400};
        vecs[3] = '{spk: 8'hFF, d: 7, lat: 35, cnt: 32'h4444_4444};

        rst_n = 1'b0; start = 1'b0; coring = 1'b0; ack = 1'b0; spk = 8'h00;
        d2_start = 1'b0; d2_coring = 1'b0; d2_ack = 1'b0; d2_spk = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(req), 0);
        chk("rst_ts", 64'(ts), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_cnt", 64'(cnt), 0);
        rst_n = 1'b1;
        tick();

        // Table: spike pattern and ack delay per step; d=7 puts the ack on the timeout edge.
        foreach (vecs[k]) begin
            start_run();
            chk("busy_after_start", 64'(busy), 1);
            chk("ts_after_start", 64'(ts), 0);
            for (int i = 0; i < T; i++) begin
                if (i == T - 1) done_q.push_back(done_exp_t'{vecs[k].cnt, 1'b0});
                ack_step(vecs[k].spk, vecs[k].d, i);
            end
            chk("done_latency", 64'(edge_cnt), 64'(vecs[k].lat));
            chk("done_pulse", 64'(done), 1);
            chk("busy_at_done", 64'(busy), 0);
            tick();
            chk("done_one_cycle", 64'(done), 0);
            chk("count_hold", 64'(cnt), 64'(vecs[k].cnt));
            chk("ts_q_drained", 64'(ts_q.size()), 0);
            chk("done_q_drained", 64'(done_q.size()), 0);
        end

        // Timeout waiting on step 1.
        start_run();
        ack_step(8'h03, 0, 0);
        done_q.push_back(done_exp_t'{32'h0000_0011, 1'b1});
        tick();
        held = 0;
        for (int i = 0; i < ACK_TO + 2 && !done; i++) begin
            if (req && ts == 1) held++;
            tick();
        end
        chk("timeout_req_cycles", 64'(held), 64'(ACK_TO));
        chk("timeout_done", 64'(done), 1);
        chk("timeout_err", 64'(err), 1);
        chk("timeout_req_low", 64'(req), 0);
        tick();
        chk("timeout_err_sticky", 64'(err), 1);
        chk("timeout_done_q", 64'(done_q.size()), 0);

        // Abort while waiting on step 2, then restart.
        start_run();
        chk("start_clears_err", 64'(err), 0);
        chk("start_clears_cnt", 64'(cnt), 0);
        ack_step(8'hF0, 0, 0);
        ack_step(8'hF0, 0, 1);
        tick();
        chk("abort_wait_ts", 64'(ts), 2);
        coring = 1'b0;
        tick();
        chk("abort_req", 64'(req), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_cnt_kept", 64'(cnt), 64'(model_cnt(8'hF0, 2)));
        repeat (3) tick();
        full_run(8'h10, 7);

        // Stray ack in IDLE, start while busy, stray acks in GAP.
        ack = 1'b1; spk = 8'hFF;
        tick();
        ack = 1'b0; spk = 8'h00;
        chk("idle_ack_ignored", 64'(cnt), 64'(model_cnt(8'h10, T)));
        chk("idle_req", 64'(req), 0);
        start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ignored_ts", 64'(ts), 0);
        chk("restart_ignored_req", 64'(req), 1);
        for (int i = 0; i < T; i++) begin
            if (i == T - 1) done_q.push_back(done_exp_t'{model_cnt(8'h02, T), 1'b0});
            ack_step(8'h02, 0, i);
            if (i < T - 1) begin
                ack = 1'b1; spk = 8'hFF; start = 1'b1;
                tick();
                ack = 1'b0; spk = 8'h00; start = 1'b0;
            end
        end
        chk("stray_latency", 64'(edge_cnt), 64'(2 * T));
        chk("stray_done", 64'(done), 1);
        tick();

        // Asynchronous reset mid-run.
        start_run();
        ack_step(8'h01, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 64'(req), 0);
        chk("arst_ts", 64'(ts), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_cnt", 64'(cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        full_run(8'h81, 7);
        chk("final_ts_q", 64'(ts_q.size()), 0);

        // Saturation with T=20.
        d2_start = 1'b1; d2_coring = 1'b1;
        tick();
        d2_start = 1'b0;
        bad = 0;
        for (int i = 0; i < T2; i++) begin
            w = 0;
            while (!d2_req && w < 4) begin
                tick();
                w++;
            end
            if (!d2_req || d2_ts != TW2'(i)) bad++;
            d2_ack = 1'b1; d2_spk = 8'h80;
            tick();
            d2_ack = 1'b0; d2_spk = 8'h00;
        end
        chk("sat_step_seq_bad", 64'(bad), 0);
        chk("sat_done", 64'(d2_done), 1);
        chk("sat_count", 64'(d2_cnt), 64'(32'hF000_0000));
        repeat (3) tick();
        chk("sat_done_once", 64'(d2_done_n), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
